// File: rtl/misr_signature_compactor.sv
// -----------------------------------------------------------------------------
// misr_signature_compactor
//
// Purpose
//   Output-response compactor placed directly after the adder-subtractor CUT.
//   One CUT response is absorbed per applied test vector into a WIDTH-bit
//   multiple-input signature register (MISR). After VEC_COUNT responses the
//   block stops, holds the signature, and reports pass/fail against a golden
//   signature. One end-of-test compare replaces a per-vector comparison.
//
// Optional feature
//   MISR_DIRECT_CMP_EN : when defined, adds a per-vector direct comparison
//   against a fault-free reference stream. It provides a sticky mismatch flag
//   and the index of the first failing vector, and gates pass with !mismatch.
//   When undefined, those ports and their logic are absent.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      begin a run; honoured in IDLE and DONE only
//   in_valid   in   1      in_data carries a CUT response this cycle
//   in_data    in   WIDTH  CUT response
//   golden     in   WIDTH  expected signature; only meaningful in DONE
//   busy       out  1      high while a run is in progress
//   done       out  1      high (level) once VEC_COUNT responses are absorbed
//   pass       out  1      done && signature == golden (0 outside DONE)
//   signature  out  WIDTH  current MISR contents
//   vec_idx    out  CNT_W  responses absorbed in this run
//   dbgState   out  2      FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
//   ref_valid  in   1      (MISR_DIRECT_CMP_EN) qualifies ref_data with in_valid
//   ref_data   in   WIDTH  (MISR_DIRECT_CMP_EN) fault-free response
//   mismatch   out  1      (MISR_DIRECT_CMP_EN) sticky response mismatch
//   first_fail out  CNT_W  (MISR_DIRECT_CMP_EN) vec_idx of first mismatch
//
// Input handshake
//   in_valid is a pure valid strobe with no back-pressure: a response is
//   consumed on every rising edge where in_valid is high and the FSM is in
//   RUN. Responses presented in IDLE or DONE are dropped. Gaps (in_valid low)
//   are allowed for any length; nothing times out.
// -----------------------------------------------------------------------------
module misr_signature_compactor #(
    parameter int               WIDTH     = 9,
    parameter logic [WIDTH-1:0] POLY      = 9'h011,
    parameter logic [WIDTH-1:0] SEED      = 9'h000,
    parameter int               VEC_COUNT = 114,
    localparam int              CNT_W     = $clog2(VEC_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] golden,
`ifdef MISR_DIRECT_CMP_EN
    input  logic             ref_valid,
    input  logic [WIDTH-1:0] ref_data,
    output logic             mismatch,
    output logic [CNT_W-1:0] first_fail,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] vec_idx,
    output logic [1:0]       dbgState
);

    // -------------------------------------------------------------------------
    // Elaboration-time sanity: a run must absorb at least one response.
    // -------------------------------------------------------------------------
    if (VEC_COUNT < 1) begin : gBadVecCount
        $error("misr_signature_compactor: VEC_COUNT must be >= 1");
    end

    // Index of the response that completes a run.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_COUNT - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;

    logic [WIDTH-1:0] sigReg;
    logic [CNT_W-1:0] vecIdxReg;
    logic             busyReg;
    logic             doneReg;

    // Control strobes produced by the next-state logic.
    logic             loadSeed;   // reseed signature and clear the counter
    logic             absorb;     // fold in_data into the signature

    logic [WIDTH-1:0] sigShifted;
    logic [WIDTH-1:0] sigNext;

    // -------------------------------------------------------------------------
    // MISR step: shift left by one, feed the bit shifted out back through the
    // polynomial taps, then XOR the parallel response in. Pure XOR, no carries.
    // -------------------------------------------------------------------------
    always_comb begin
        sigShifted = {sigReg[WIDTH-2:0], 1'b0};
        sigNext    = sigShifted ^ (sigReg[WIDTH-1] ? POLY : '0) ^ in_data;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        nextState = state;
        loadSeed  = 1'b0;
        absorb    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nextState = ST_RUN;
                    loadSeed  = 1'b1;
                end
            end
            ST_RUN: begin
                // start is deliberately not examined here: only reset aborts.
                if (in_valid) begin
                    absorb = 1'b1;
                    if (vecIdxReg == LAST_IDX) begin
                        nextState = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    nextState = ST_RUN;
                    loadSeed  = 1'b1;
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and datapath. busy/done are registered from nextState so
    // they line up exactly with the state they decode.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sigReg    <= SEED;
            vecIdxReg <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            state   <= nextState;
            busyReg <= (nextState == ST_RUN);
            doneReg <= (nextState == ST_DONE);
            if (loadSeed) begin
                sigReg    <= SEED;
                vecIdxReg <= '0;
            end else if (absorb) begin
                sigReg    <= sigNext;
                vecIdxReg <= vecIdxReg + IDX_ONE;
            end
        end
    end

`ifdef MISR_DIRECT_CMP_EN
    // -------------------------------------------------------------------------
    // Direct response comparison. Only responses that are actually absorbed
    // are compared, so the recorded index matches the vector number in the
    // signature. The first mismatch index is captured once and held.
    // -------------------------------------------------------------------------
    logic             mismatchReg;
    logic [CNT_W-1:0] firstFailReg;
    logic             compareHit;

    always_comb begin
        compareHit = absorb && ref_valid && (in_data != ref_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatchReg  <= 1'b0;
            firstFailReg <= '0;
        end else if (loadSeed) begin
            mismatchReg  <= 1'b0;
            firstFailReg <= '0;
        end else if (compareHit && !mismatchReg) begin
            mismatchReg  <= 1'b1;
            firstFailReg <= vecIdxReg;
        end
    end

    assign mismatch   = mismatchReg;
    assign first_fail = firstFailReg;
    assign pass       = doneReg && (sigReg == golden) && !mismatchReg;
`else
    // Signature compare only; golden is live combinationally while in DONE.
    assign pass       = doneReg && (sigReg == golden);
`endif

    assign busy      = busyReg;
    assign done      = doneReg;
    assign signature = sigReg;
    assign vec_idx   = vecIdxReg;
    assign dbgState  = state;

endmodule

// File: tb/tb_misr_signature_compactor.sv
// -----------------------------------------------------------------------------
// tb_misr_signature_compactor
//
// Bench for misr_signature_compactor with VEC_COUNT = 3. Inputs change on the
// falling edge; outputs are checked on the following falling edge. Each
// driven cycle pushes the expected signature onto exp_q, which is popped when
// the DUT output for that cycle is examined.
// -----------------------------------------------------------------------------
module tb_misr_signature_compactor;

    localparam int         W   = 9;
    localparam int         VC  = 3;
    localparam int         CW  = $clog2(VC + 1);
    localparam logic [W-1:0] P_POLY = 9'h011;
    localparam logic [W-1:0] P_SEED = 9'h000;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data  = '0;
    logic [W-1:0]  golden   = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [W-1:0]  signature;
    logic [CW-1:0] vec_idx;
    logic [1:0]    dbgState;
`ifdef MISR_DIRECT_CMP_EN
    logic          ref_valid = 1'b0;
    logic [W-1:0]  ref_data  = '0;
    logic          mismatch;
    logic [CW-1:0] first_fail;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state: 0 = IDLE, 1 = RUN, 2 = DONE.
    int           mState = 0;
    logic [W-1:0] mSig   = P_SEED;
    int           mIdx   = 0;
    logic         mMis   = 1'b0;
    int           mFirst = 0;

    misr_signature_compactor #(
        .WIDTH     (W),
        .POLY      (P_POLY),
        .SEED      (P_SEED),
        .VEC_COUNT (VC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .golden     (golden),
`ifdef MISR_DIRECT_CMP_EN
        .ref_valid  (ref_valid),
        .ref_data   (ref_data),
        .mismatch   (mismatch),
        .first_fail (first_fail),
`endif
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .vec_idx    (vec_idx),
        .dbgState   (dbgState)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- checker
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Polynomial division step written straight from the MISR definition.
    function automatic logic [W-1:0] misrModel(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = s << 1;
        if (s[W-1]) r = r ^ P_POLY;
        return r ^ d;
    endfunction

    function automatic logic modelPass();
        logic p;
        p = (mState == 2) && (mSig == golden);
`ifdef MISR_DIRECT_CMP_EN
        p = p && !mMis;
`endif
        return p;
    endfunction

    // Pop the scoreboard entry for this cycle and compare every output.
    task automatic checkOutputs(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checkVal({tag, "_qempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkVal({tag, "_sig"}, 32'(signature), 32'(e));
        end
        checkVal({tag, "_idx"},   32'(vec_idx),  32'(mIdx));
        checkVal({tag, "_busy"},  32'(busy),     32'(mState == 1));
        checkVal({tag, "_done"},  32'(done),     32'(mState == 2));
        checkVal({tag, "_state"}, 32'(dbgState), 32'(mState));
        checkVal({tag, "_pass"},  32'(pass),     32'(modelPass()));
`ifdef MISR_DIRECT_CMP_EN
        checkVal({tag, "_mis"},   32'(mismatch),   32'(mMis));
        checkVal({tag, "_ffail"}, 32'(first_fail), 32'(mFirst));
`endif
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n  = 1'b1;
        mState = 0;
        mSig   = P_SEED;
        mIdx   = 0;
        mMis   = 1'b0;
        mFirst = 0;
        exp_q.push_back(mSig);
        checkOutputs("reset");
    endtask

    task automatic startPulse(input string tag);
        @(negedge clk);
        start = 1'b1;
        if (mState != 1) begin
            mState = 1;
            mSig   = P_SEED;
            mIdx   = 0;
            mMis   = 1'b0;
            mFirst = 0;
        end
        exp_q.push_back(mSig);
        @(negedge clk);
        start = 1'b0;
        checkOutputs(tag);
    endtask

    task automatic sendResp(input string tag, input logic [W-1:0] d,
                            input logic refV, input logic [W-1:0] refD);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
`ifdef MISR_DIRECT_CMP_EN
        ref_valid = refV;
        ref_data  = refD;
        if (mState == 1 && refV && d != refD && !mMis) begin
            mMis   = 1'b1;
            mFirst = mIdx;
        end
`else
        if (refV && refD != d) begin
            // reference stream has no effect without the direct-compare build
        end
`endif
        if (mState == 1) begin
            mSig = misrModel(mSig, d);
            mIdx++;
            if (mIdx == VC) mState = 2;
        end
        exp_q.push_back(mSig);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef MISR_DIRECT_CMP_EN
        ref_valid = 1'b0;
`endif
        checkOutputs(tag);
    endtask

    task automatic idleCycle(input string tag);
        exp_q.push_back(mSig);
        @(negedge clk);
        checkOutputs(tag);
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [W-1:0] vecs[VC];
    logic [W-1:0] b2bSig;

    initial begin
        // Reset held for two clocks.
        applyReset(2);

        // Responses in IDLE are dropped.
        sendResp("idle_drop", 9'h1AB, 1'b1, 9'h1AB);

        // Basic run: 001, 000, 000 -> 001, 002, 004.
        startPulse("start1");
        golden = 9'h001;                      // matches mid-run, pass must stay 0
        sendResp("r1_v0", 9'h001, 1'b1, 9'h001);
        checkVal("r1_sig0_const", 32'(signature), 32'h001);
        sendResp("r1_v1", 9'h000, 1'b1, 9'h000);
        checkVal("r1_sig1_const", 32'(signature), 32'h002);
        sendResp("r1_v2", 9'h000, 1'b1, 9'h000);
        checkVal("r1_sig2_const", 32'(signature), 32'h004);
        checkVal("r1_done_const", 32'(done), 32'd1);
        golden = 9'h004;
        #1 checkVal("r1_pass_good", 32'(pass), 32'd1);
        golden = 9'h005;
        #1 checkVal("r1_pass_bad", 32'(pass), 32'd0);

        // DONE ignores in_valid and holds.
        sendResp("done_drop", 9'h155, 1'b1, 9'h155);

        // Restart from DONE, then exercise the feedback wrap.
        startPulse("start_from_done");
        sendResp("wrap_v0", 9'h100, 1'b1, 9'h100);
        checkVal("wrap_sig0_const", 32'(signature), 32'h100);
        sendResp("wrap_v1", 9'h000, 1'b1, 9'h000);
        checkVal("wrap_sig1_const", 32'(signature), 32'h011);
        startPulse("start_in_run");          // must be ignored
        sendResp("wrap_v2", 9'(($urandom_range(0, 511))), 1'b1, 9'h000 /* ref unused here */);
        golden = mSig;
        idleCycle("wrap_done");

        // Back-to-back reference run, then the same data with 5-cycle gaps.
        for (int i = 0; i < VC; i++) vecs[i] = 9'($urandom_range(0, 511));
        startPulse("b2b_start");
        for (int i = 0; i < VC; i++) sendResp("b2b", vecs[i], 1'b0, '0);
        b2bSig = mSig;
        startPulse("sparse_start");
        for (int i = 0; i < VC; i++) begin
            sendResp("sparse", vecs[i], 1'b0, '0);
            if (i != VC - 1) repeat (5) idleCycle("sparse_gap");
        end
        checkVal("sparse_eq", 32'(signature), 32'(b2bSig));

        // Reset mid-run after two of three responses.
        startPulse("midrst_start");
        sendResp("midrst_v0", 9'h0F0, 1'b0, '0);
        sendResp("midrst_v1", 9'h00F, 1'b0, '0);
        applyReset(1);
        checkVal("midrst_done", 32'(done), 32'd0);
        idleCycle("midrst_idle");

        // Randomised runs with random gaps and a good or corrupted golden.
        for (int r = 0; r < 20; r++) begin
            logic [W-1:0] d;
            startPulse("rnd_start");
            for (int i = 0; i < VC; i++) begin
                d = 9'($urandom_range(0, 511));
                sendResp("rnd", d, 1'b1, d);
                repeat ($urandom_range(0, 2)) idleCycle("rnd_gap");
            end
            golden = ($urandom_range(0, 1) == 1) ? mSig : (mSig ^ 9'h001);
            #1 checkVal("rnd_pass", 32'(pass), 32'(golden == mSig));
        end

`ifdef MISR_DIRECT_CMP_EN
        // Direct compare: vector 1 differs from its reference.
        startPulse("dc_start");
        sendResp("dc_v0", 9'h0AA, 1'b1, 9'h0AA);
        sendResp("dc_v1", 9'h0A0, 1'b1, 9'h0A1);
        sendResp("dc_v2", 9'h033, 1'b1, 9'h034);   // later mismatch keeps index 1
        golden = mSig;
        #1;
        checkVal("dc_mismatch", 32'(mismatch), 32'd1);
        checkVal("dc_first_fail", 32'(first_fail), 32'd1);
        checkVal("dc_pass", 32'(pass), 32'd0);
        startPulse("dc_restart");
        checkVal("dc_clear", 32'(mismatch), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
